// File: rtl/ntt_stride_permutation_if.sv
// Stream bundle for the NTT lane permutation: framed input beats in, permuted
// framed beats plus status out.
interface ntt_stride_permutation_if #(
  parameter int DATA_WIDTH_PER_INPUT = 32,
  parameter int INPUT_PER_CYCLE      = 32
);
  localparam int LOG2_LANES = $clog2(INPUT_PER_CYCLE);
  localparam int CFG_W      = $clog2(LOG2_LANES) + 1;
  localparam int BUS_W      = INPUT_PER_CYCLE * DATA_WIDTH_PER_INPUT;

  logic             inStart;
  logic [CFG_W-1:0] cfgSwapBit;
  logic [BUS_W-1:0] inData;
  logic [BUS_W-1:0] outData;
  logic             outStart;
  logic             outValid;
  logic             busy;
  logic             cfgErr;
  logic             seqErr;

  modport master (
    output inStart, cfgSwapBit, inData,
    input  outData, outStart, outValid, busy, cfgErr, seqErr
  );

  modport slave (
    input  inStart, cfgSwapBit, inData,
    output outData, outStart, outValid, busy, cfgErr, seqErr
  );
endinterface

// File: rtl/ntt_stride_permutation.sv
// Runtime-configurable lane permutation (swap lane-index bit 0 with bit S),
// pipelined with frame start/valid tracking and sticky config/sequence errors.
module ntt_stride_permutation #(
  parameter int DATA_WIDTH_PER_INPUT = 32,
  parameter int INPUT_PER_CYCLE      = 32,
  parameter int FRAME_CYCLES         = 32,
  parameter int PIPE_STAGES          = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  ntt_stride_permutation_if.slave bus
);
  localparam int LOG2_LANES = $clog2(INPUT_PER_CYCLE);
  localparam int W          = DATA_WIDTH_PER_INPUT;
  localparam int BUS_W      = INPUT_PER_CYCLE * W;
  localparam int CFG_W      = $clog2(LOG2_LANES) + 1;
  localparam int CNT_W      = $clog2(FRAME_CYCLES) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CFG_W-1:0] swap_reg;
  logic [CFG_W-1:0] swap_active;
  logic             cfg_legal;
  logic             cfg_err_reg, seq_err_reg;
  logic             busy, in_valid, seq_err_set, last_beat;

  logic [BUS_W-1:0] perm_data;
  logic [BUS_W-1:0] data_pipe [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] start_pipe, valid_pipe;

  function automatic logic [LOG2_LANES-1:0] swap_lane(
    input logic [LOG2_LANES-1:0] j,
    input logic [CFG_W-1:0]      s
  );
    logic [LOG2_LANES-1:0] r;
    r = j;
    for (int b = 1; b < LOG2_LANES; b++) begin
      if (int'(s) == b) begin
        r[0] = j[b];
        r[b] = j[0];
      end
    end
    return r;
  endfunction

  // A new swap bit takes effect on the very beat that carries inStart.
  assign cfg_legal   = int'(bus.cfgSwapBit) <= (LOG2_LANES - 1);
  assign swap_active = bus.inStart ? (cfg_legal ? bus.cfgSwapBit : '0) : swap_reg;

  // The map is an involution, so each output lane reads from p(lane).
  generate
    for (genvar gi = 0; gi < INPUT_PER_CYCLE; gi++) begin : g_lane
      logic [LOG2_LANES-1:0] src;
      assign src = swap_lane(LOG2_LANES'(gi), swap_active);
      assign perm_data[gi*W +: W] = bus.inData[int'(src)*W +: W];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign last_beat = (cnt_reg == CNT_W'(FRAME_CYCLES - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.inStart && FRAME_CYCLES > 1) begin
          state_next = RUN;
          cnt_next   = CNT_W'(1);
        end
      end
      RUN: begin
        if (bus.inStart) begin
          state_next = RUN;
          cnt_next   = CNT_W'(1);
        end else if (last_beat) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Any inStart seen while RUN is mid-frame; the frame ends by going back to IDLE.
  always_comb begin
    busy        = (state_reg == RUN);
    in_valid    = bus.inStart || (state_reg == RUN);
    seq_err_set = bus.inStart && (state_reg == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_reg    <= '0;
      cfg_err_reg <= 1'b0;
      seq_err_reg <= 1'b0;
    end else begin
      if (bus.inStart) begin
        swap_reg <= swap_active;
        if (!cfg_legal) cfg_err_reg <= 1'b1;
      end
      if (seq_err_set) seq_err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_STAGES; i++) data_pipe[i] <= '0;
      start_pipe <= '0;
      valid_pipe <= '0;
    end else begin
      data_pipe[0]  <= perm_data;
      start_pipe[0] <= bus.inStart;
      valid_pipe[0] <= in_valid;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        data_pipe[i]  <= data_pipe[i-1];
        start_pipe[i] <= start_pipe[i-1];
        valid_pipe[i] <= valid_pipe[i-1];
      end
    end
  end

  assign bus.outData  = data_pipe[PIPE_STAGES-1];
  assign bus.outStart = start_pipe[PIPE_STAGES-1];
  assign bus.outValid = valid_pipe[PIPE_STAGES-1];
  assign bus.busy     = busy;
  assign bus.cfgErr   = cfg_err_reg;
  assign bus.seqErr   = seq_err_reg;

endmodule
